// File: rtl/dat_mmio_bridge.sv
// Splits the core data port between data SRAM and an MMIO page holding an
// 8N1 UART transmitter with TX FIFO and a free-running cycle counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line high, waiting for a FIFO entry
// S_START | driving the start bit (low) for CLK_DIV cycles
// S_DATA  | shifting out 8 data bits LSB first, CLK_DIV cycles each
// S_STOP  | driving the stop bit (high); chains straight into the next frame
module dat_mmio_bridge #(
  parameter logic [3:0] MMIO_BASE  = 4'hF,
  parameter int         CLK_DIV    = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dat_a,
  input  logic [3:0]  dat_we,
  input  logic [31:0] dat_wd,
  input  logic [3:0]  dat_re,
  output logic [31:0] dat_rd,
  output logic [15:0] sram_a,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_wd,
  output logic [3:0]  sram_re,
  input  logic [31:0] sram_rd,
  output logic        uart_tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   mtime_q, mtime_d;
  logic          sel_q, sel_d;
  logic [31:0]   mmio_rd_q, mmio_rd_d;

  logic          mmio, full, empty, busy, baud_last;
  logic          push_req, push_ok, pop;
  logic [2:0]    idx;
  logic [31:0]   status, rd_val;

  always_comb begin
    mmio    = (dat_a[15:12] == MMIO_BASE);
    idx     = dat_a[4:2];
    sram_a  = dat_a;
    sram_wd = dat_wd;
    sram_we = mmio ? 4'h0 : dat_we;
    sram_re = mmio ? 4'h0 : dat_re;
    dat_rd  = sel_q ? mmio_rd_q : sram_rd;
    uart_tx = tx_q;
  end

  always_comb begin
    full   = (count_q == CW'(FIFO_DEPTH));
    empty  = (count_q == '0);
    busy   = (state_q != S_IDLE) || !empty;
    status = {16'h0, {(8 - CW){1'b0}}, count_q, 4'h0, ovf_q, empty, full, busy};
    case (idx)
      3'd1:    rd_val = status;
      3'd2:    rd_val = mtime_q;
      default: rd_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    baud_last = (baud_q == BAUD_LAST);
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chaining directly into START keeps back-to-back frames gapless.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_req = mmio && dat_we[0] && (idx == 3'd0);
    push_ok  = push_req && !full;
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = dat_wd[7:0];
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (push_req && full) ovf_d = 1'b1;
    else if (mmio && dat_we[0] && (idx == 3'd1) && dat_wd[3]) ovf_d = 1'b0;
    mtime_d   = mtime_q + 32'd1;
    sel_d     = sel_q;
    mmio_rd_d = mmio_rd_q;
    // Sampled from pre-write state so a same-cycle write is not visible.
    if (|dat_re) begin
      sel_d     = mmio;
      mmio_rd_d = rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      mtime_q   <= '0;
      sel_q     <= 1'b1;
      mmio_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      mtime_q   <= mtime_d;
      sel_q     <= sel_d;
      mmio_rd_q <= mmio_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_dat_mmio_bridge.sv
// Directed and randomized bench for dat_mmio_bridge with an SRAM model,
// a shadow memory, and a serial receiver that decodes uart_tx frames.
module tb_dat_mmio_bridge;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dat_a = '0;
  logic [3:0]  dat_we = '0;
  logic [31:0] dat_wd = '0;
  logic [3:0]  dat_re = '0;
  logic [31:0] dat_rd;
  logic [15:0] sram_a;
  logic [3:0]  sram_we;
  logic [31:0] sram_wd;
  logic [3:0]  sram_re;
  logic [31:0] sram_rd;
  logic        uart_tx;

  dat_mmio_bridge #(.MMIO_BASE(4'hF), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd),
    .dat_re(dat_re), .dat_rd(dat_rd), .sram_a(sram_a), .sram_we(sram_we),
    .sram_wd(sram_wd), .sram_re(sram_re), .sram_rd(sram_rd), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model with one-cycle read latency
  logic [31:0] env_mem [1024];
  logic [31:0] sram_rd_r = 32'hA5A5A5A5;
  assign sram_rd = sram_rd_r;
  always @(posedge clk) begin
    if (|sram_re) sram_rd_r <= env_mem[sram_a[11:2]];
    for (int i = 0; i < 4; i++)
      if (sram_we[i]) env_mem[sram_a[11:2]][8*i +: 8] <= sram_wd[8*i +: 8];
  end

  // Serial receiver: samples mid-bit, records byte and start cycle
  logic [7:0] rx_q [$];
  int         rx_t [$];
  int         rx_st;
  logic [7:0] rx_b;
  always begin
    @(negedge clk);
    if (!rst && uart_tx === 1'b0) begin
      rx_st = cyc;
      repeat (CLK_DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clk);
        rx_b[i] = uart_tx;
      end
      repeat (CLK_DIV) @(negedge clk);
      rx_q.push_back(rx_b);
      rx_t.push_back(rx_st);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] wd, input logic [3:0] we);
    dat_a = a; dat_wd = wd; dat_we = we;
    step();
    dat_we = '0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [3:0] re, output logic [31:0] d);
    dat_a = a; dat_re = re;
    step();
    d = dat_rd;
    dat_re = '0;
  endtask

  function automatic logic [31:0] status_word(int cnt, bit ovf, bit busy);
    return {16'h0, 8'(cnt), 4'h0, ovf, (cnt == 0), (cnt == DEPTH), busy};
  endfunction

  function automatic logic exp_tx(int k, logic [7:0] b);
    if (k < CLK_DIV) return 1'b0;
    if (k < 9 * CLK_DIV) return b[(k - CLK_DIV) / CLK_DIV];
    return 1'b1;
  endfunction

  task automatic check_frames(input string tag, input logic [7:0] exp_b [$]);
    int budget;
    budget = 0;
    while (rx_q.size() < exp_b.size() && budget < (exp_b.size() + 2) * 10 * CLK_DIV) begin
      step();
      budget++;
    end
    chk({tag, "_nframes"}, rx_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
      chk({tag, "_byte"}, rx_q[i], exp_b[i]);
      if (i > 0) chk({tag, "_spacing"}, rx_t[i] - rx_t[i-1], 10 * CLK_DIV);
    end
  endtask

  logic [31:0] d, d2;
  logic [7:0]  exp_b [$];
  logic [31:0] shadow [int];
  logic [15:0] addrs [$];
  bit          bad;

  initial begin
    // Reset and initial state
    step(); step();
    rst = 1'b0;
    chk("rst_dat_rd", dat_rd, 32'h0);
    chk("rst_uart_tx", uart_tx, 32'h1);

    // MTIME: cycle 0 is the first cycle after reset
    repeat (10) step();
    rd(16'hF008, 4'hF, d);
    repeat (9) step();
    rd(16'hF008, 4'hF, d2);
    chk("mtime_at10", d, 32'd10);
    chk("mtime_delta", d2 - d, 32'd10);
    dat_re = 4'hF;
    wr(16'hF008, 32'h1234, 4'hF);
    dat_re = '0;
    chk("mtime_rdwr_same_cycle", dat_rd, 32'd21);
    rd(16'hF008, 4'b1000, d);
    chk("mtime_write_ignored", d, 32'd22);
    rd(16'hF004, 4'hF, d);
    chk("status_after_reset", d, status_word(0, 0, 0));
    rd(16'hF000, 4'hF, d);
    chk("txdata_reads_zero", d, 32'h0);

    // SRAM passthrough
    dat_a = 16'h0010; dat_wd = 32'hDEADBEEF; dat_we = 4'hF;
    #1;
    chk("sram_we_pass", sram_we, 4'hF);
    chk("sram_a_pass", sram_a, 16'h0010);
    chk("sram_wd_pass", sram_wd, 32'hDEADBEEF);
    step();
    dat_we = '0;
    rd(16'h0010, 4'hF, d);
    chk("sram_read", d, 32'hDEADBEEF);
    dat_a = 16'hF004; dat_re = 4'hF; dat_we = 4'hF; dat_wd = 32'h0;
    #1;
    chk("sram_re_mmio", sram_re, 4'h0);
    chk("sram_we_mmio", sram_we, 4'h0);
    step();
    dat_re = '0; dat_we = '0;

    // Unmapped and byte lanes
    rd(16'hF01C, 4'hF, d);
    chk("unmapped_read", d, 32'h0);
    wr(16'hF000, 32'h000000AB, 4'b0010);
    bad = 0;
    repeat (8) begin step(); if (uart_tx !== 1'b1) bad = 1; end
    chk("lane_no_frame", bad, 0);
    rd(16'hF004, 4'hF, d);
    chk("lane_no_push", d, status_word(0, 0, 0));

    // Single byte, exact waveform
    wr(16'hF000, 32'h55, 4'h1);
    chk("single_tx_T1", uart_tx, 32'h1);
    bad = 0;
    for (int k = 0; k < 10 * CLK_DIV; k++) begin
      if (k == 20) begin dat_a = 16'hF004; dat_re = 4'hF; end
      step();
      if (k == 20) dat_re = '0;
      if (k == 21) chk("single_busy_mid", dat_rd[0], 32'h1);
      if (uart_tx !== exp_tx(k, 8'h55)) bad = 1;
    end
    chk("single_waveform", bad, 0);
    step(); step();
    rd(16'hF004, 4'hF, d);
    chk("single_status_after", d, 32'h4);
    rx_q.delete(); rx_t.delete();

    // Back-to-back and overflow
    for (int i = 1; i <= 6; i++) wr(16'hF000, 32'(i), 4'h1);
    rd(16'hF004, 4'hF, d);
    chk("ovf_status", d, status_word(4, 1, 1));
    dat_re = 4'hF;
    wr(16'hF004, 32'h8, 4'h1);
    dat_re = '0;
    chk("ovf_clear_rd_prewrite", dat_rd[3], 32'h1);
    rd(16'hF004, 4'hF, d);
    chk("ovf_cleared", d, status_word(4, 0, 1));
    exp_b.delete();
    for (int i = 1; i <= 5; i++) exp_b.push_back(8'(i));
    check_frames("ovf", exp_b);
    repeat (6) step();
    rx_q.delete(); rx_t.delete();

    // Random SRAM traffic against a shadow memory
    addrs.delete();
    for (int i = 0; i < 12; i++) begin
      logic [15:0] a;
      logic [31:0] v;
      a = {4'($urandom_range(0, 14)), 2'b00, 8'(i * 21 + $urandom_range(0, 20)), 2'b00};
      v = $urandom;
      wr(a, v, 4'hF);
      shadow[int'(a[11:2])] = v;
      addrs.push_back(a);
    end
    for (int i = 0; i < 12; i++) begin
      logic [15:0] a;
      logic [31:0] v;
      logic [3:0]  we;
      a = addrs[$urandom_range(0, 11)];
      v = $urandom;
      we = 4'($urandom_range(1, 15));
      dat_a = a; dat_wd = v; dat_we = we;
      #1;
      chk("rand_sram_we", sram_we, we);
      step();
      dat_we = '0;
      for (int b = 0; b < 4; b++)
        if (we[b]) shadow[int'(a[11:2])][8*b +: 8] = v[8*b +: 8];
    end
    foreach (addrs[i]) begin
      logic [2:0] ui;
      rd(addrs[i], 4'($urandom_range(1, 15)), d);
      chk("rand_sram_rd", d, shadow[int'(addrs[i][11:2])]);
      ui = 3'($urandom_range(3, 7));
      rd({4'hF, 7'h0, ui, 2'($urandom)}, 4'hF, d);
      chk("rand_unmapped_rd", d, 32'h0);
    end

    // Random UART bursts
    for (int r = 0; r < 3; r++) begin
      int n, kept, cnt;
      n = $urandom_range(1, 6);
      kept = (n > DEPTH + 1) ? DEPTH + 1 : n;
      cnt = (n == 1) ? 1 : kept - 1;
      exp_b.delete();
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        wr(16'hF000, {24'($urandom), b}, 4'h1);
        if (i < kept) exp_b.push_back(b);
      end
      rd(16'hF004, 4'hF, d);
      chk("burst_status", d, status_word(cnt, n > DEPTH + 1, 1));
      wr(16'hF004, 32'h8, 4'h1);
      check_frames("burst", exp_b);
      repeat (6) step();
      rd(16'hF004, 4'hF, d);
      chk("burst_drained", d, 32'h4);
      rx_q.delete(); rx_t.delete();
    end

    // Reset mid-frame with two bytes queued
    wr(16'hF000, 32'h11, 4'h1);
    wr(16'hF000, 32'h22, 4'h1);
    wr(16'hF000, 32'h33, 4'h1);
    repeat (15) step();
    rst = 1'b1;
    step();
    chk("midrst_tx_high", uart_tx, 32'h1);
    chk("midrst_dat_rd", dat_rd, 32'h0);
    rst = 1'b0;
    rd(16'hF004, 4'hF, d);
    chk("midrst_status", d, 32'h4);
    bad = 0;
    repeat (60) begin step(); if (uart_tx !== 1'b1) bad = 1; end
    rx_q.delete(); rx_t.delete();
    repeat (60) begin step(); if (uart_tx !== 1'b1) bad = 1; end
    chk("midrst_line_idle", bad, 0);
    chk("midrst_no_frames", rx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
